// File: rtl/adc_fir_pkg.sv
// Shared types, widths and the fixed coefficient set for the ADC FIR stage.
package adc_fir_pkg;

  localparam int unsigned TAPS_DEF = 16;
  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned COEF_W   = 16;
  localparam int unsigned ADC_W    = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    RND  = 2'd2
  } state_t;

  // Symmetric low-pass taps in Q1.15; their sum (30208) stays below unity gain.
  localparam logic signed [COEF_W-1:0] COEF [0:TAPS_DEF-1] = '{
    -16'sd256, 16'sd0,    16'sd512,  16'sd1024,
     16'sd2048, 16'sd3072, 16'sd4096, 16'sd4608,
     16'sd4608, 16'sd4096, 16'sd3072, 16'sd2048,
     16'sd1024, 16'sd512,  16'sd0,   -16'sd256
  };

  localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 16'sh8000;

  // 12-bit offset-binary ADC code to Q1.15.
  function automatic logic signed [SAMPLE_W-1:0] adc_to_q15(input logic [ADC_W-1:0] s);
    return {~s[ADC_W-1], s[ADC_W-2:0], 4'b0000};
  endfunction

endpackage

// File: rtl/fir_coef_rom.sv
// Combinational coefficient lookup: idx -> h[idx]; indices past the table read zero.
module fir_coef_rom
  import adc_fir_pkg::*;
#(
  parameter int unsigned TAPS  = TAPS_DEF,
  parameter int unsigned IDX_W = $clog2(TAPS)
) (
  input  logic [IDX_W-1:0]         idx,
  output logic signed [COEF_W-1:0] coef_c
);

  always_comb begin
    coef_c = '0;
    for (int unsigned k = 0; k < TAPS_DEF; k++) begin
      if (32'(idx) == k) coef_c = COEF[k];
    end
  end

endmodule

// File: rtl/adc_fir_filter.sv
// Single-multiplier sequential FIR between the serial ADC interface and the equalizer.
// Optional build macro ADC_FIR_BYPASS_EN adds a bypass port that passes the converted sample through.
module adc_fir_filter
  import adc_fir_pkg::*;
#(
  parameter int unsigned TAPS  = TAPS_DEF,
  parameter int unsigned ACC_W = 32 + $clog2(TAPS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       listo,
  input  logic [15:0]                d_out,
  output logic signed [SAMPLE_W-1:0] y_out,
  output logic                       y_valid,
  output logic                       busy,
  output logic                       overrun
`ifdef ADC_FIR_BYPASS_EN
  ,
  input  logic                       bypass
`endif
);

  localparam int unsigned IDX_W  = $clog2(TAPS);
  localparam int unsigned Q_W    = ACC_W - 15;
  localparam int unsigned PROD_W = SAMPLE_W + COEF_W;

  state_t state, state_next;
  logic   accept_c, mac_en_c, rnd_en_c;

  logic signed [SAMPLE_W-1:0] x_line [TAPS];
  logic signed [ACC_W-1:0]    acc;
  logic [IDX_W-1:0]           idx;
  logic                       bypass_q;

  logic signed [COEF_W-1:0]   coef_c;
  logic signed [PROD_W-1:0]   prod_c;
  logic signed [ACC_W-1:0]    r_c;
  logic signed [Q_W-1:0]      q_c;
  logic [Q_W-SAMPLE_W:0]      hi_c;
  logic signed [SAMPLE_W-1:0] sat_c;
  logic                       unused_bits_c;

  assign unused_bits_c = ^d_out[15:12];

  fir_coef_rom #(
    .TAPS  (TAPS),
    .IDX_W (IDX_W)
  ) u_rom (
    .idx    (idx),
    .coef_c (coef_c)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and datapath enables
  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    mac_en_c   = 1'b0;
    rnd_en_c   = 1'b0;
    unique case (state)
      IDLE: begin
        if (listo) begin
          accept_c   = 1'b1;
          state_next = MAC;
        end
      end
      MAC: begin
        mac_en_c = 1'b1;
        if (idx == IDX_W'(TAPS - 1)) state_next = RND;
      end
      RND: begin
        rnd_en_c   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Product, rounding and saturation
  always_comb begin
    prod_c = PROD_W'(x_line[idx]) * PROD_W'(coef_c);
    r_c    = acc + ACC_W'(16384);
    q_c    = Q_W'(r_c >>> 15);
    hi_c   = q_c[Q_W-1:SAMPLE_W-1];
    if ((&hi_c) || !(|hi_c)) sat_c = q_c[SAMPLE_W-1:0];
    else if (q_c[Q_W-1])     sat_c = SAT_MIN;
    else                     sat_c = SAT_MAX;
  end

`ifdef ADC_FIR_BYPASS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        bypass_q <= 1'b0;
    else if (accept_c) bypass_q <= bypass;
  end
`else
  assign bypass_q = 1'b0;
`endif

  // Delay line, accumulator and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < TAPS; k++) x_line[k] <= '0;
      acc     <= '0;
      idx     <= '0;
      y_out   <= '0;
      y_valid <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      y_valid <= rnd_en_c;
      busy    <= (state_next != IDLE);
      if (listo && (state != IDLE)) overrun <= 1'b1;
      if (accept_c) begin
        for (int unsigned k = TAPS - 1; k > 0; k--) x_line[k] <= x_line[k-1];
        x_line[0] <= adc_to_q15(d_out[ADC_W-1:0]);
        acc       <= '0;
        idx       <= '0;
      end
      if (mac_en_c) begin
        acc <= acc + ACC_W'(prod_c);
        idx <= idx + IDX_W'(1);
      end
      // Bypass reuses the newest sample, which a dropped strobe never disturbs.
      if (rnd_en_c) y_out <= bypass_q ? x_line[0] : sat_c;
    end
  end

endmodule

// File: tb/tb_adc_fir_filter.sv
// Directed, table-driven bench for adc_fir_filter with hand-computed responses.
module tb_adc_fir_filter;

  logic        clk = 1'b0;
  logic        reset;
  logic        listo;
  logic [15:0] d_out;
  logic [15:0] y_out;
  logic        y_valid;
  logic        busy;
  logic        overrun;
`ifdef ADC_FIR_BYPASS_EN
  logic        bypass;
`endif

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] d;
    logic [15:0] y;
    logic        chk;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  adc_fir_filter dut (
    .clk     (clk),
    .reset   (reset),
    .listo   (listo),
    .d_out   (d_out),
    .y_out   (y_out),
    .y_valid (y_valid),
    .busy    (busy),
    .overrun (overrun)
`ifdef ADC_FIR_BYPASS_EN
    ,
    .bypass  (bypass)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [15:0] d, input logic [15:0] y, input logic chk);
    vec_t v;
    v.d = d; v.y = y; v.chk = chk;
    tbl.push_back(v);
  endfunction

  // Strobe one sample at a negedge; return the result and the cycle y_valid was seen (-1 on timeout).
  task automatic run_sample(input logic [15:0] d, output logic [15:0] y, output int lat);
    d_out = d;
    listo = 1'b1;
    @(negedge clk);
    listo = 1'b0;
    lat   = 1;
    while (!y_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!y_valid) lat = -1;
    y = y_out;
  endtask

  task automatic apply_rows(input int first, input int last, input string tag);
    logic [15:0] y;
    int          lat;
    for (int i = first; i <= last; i++) begin
      run_sample(tbl[i].d, y, lat);
      check($sformatf("%s%0d_lat", tag, i), 32'(lat), 32'd18);
      if (tbl[i].chk) check($sformatf("%s%0d_y", tag, i), 32'(y), 32'(tbl[i].y));
    end
  endtask

  initial begin
    logic [15:0] y, yv;
    int          lat, nv, vlat;

    // Impulse 0x0FFF (0x7FF0) then midscale: floor((32752*h[k] + 16384) / 32768)
    add(16'h0FFF, 16'hFF00, 1'b1);
    add(16'h0800, 16'h0000, 1'b1);
    add(16'h0800, 16'h0200, 1'b1);
    add(16'h0800, 16'h0400, 1'b1);
    add(16'h0800, 16'h07FF, 1'b1);
    add(16'h0800, 16'h0BFF, 1'b1);
    add(16'h0800, 16'h0FFE, 1'b1);
    add(16'h0800, 16'h11FE, 1'b1);
    add(16'h0800, 16'h11FE, 1'b1);
    add(16'h0800, 16'h0FFE, 1'b1);
    add(16'h0800, 16'h0BFF, 1'b1);
    add(16'h0800, 16'h07FF, 1'b1);
    add(16'h0800, 16'h0400, 1'b1);
    add(16'h0800, 16'h0200, 1'b1);
    add(16'h0800, 16'h0000, 1'b1);
    add(16'h0800, 16'hFF00, 1'b1);
    add(16'h0800, 16'h0000, 1'b1);
    add(16'hF800, 16'h0000, 1'b1);
    // Full-scale positive DC: first output is h0 alone, settled is 30193
    add(16'h0FFF, 16'hFF00, 1'b1);
    for (int i = 0; i < 14; i++) add(16'h0FFF, 16'h0000, 1'b0);
    add(16'h0FFF, 16'h75F1, 1'b1);
    // Full-scale negative DC settles at -30208
    for (int i = 0; i < 15; i++) add(16'h0000, 16'h0000, 1'b0);
    add(16'h0000, 16'h8A00, 1'b1);

    reset = 1'b0;
    listo = 1'b0;
    d_out = '0;
`ifdef ADC_FIR_BYPASS_EN
    bypass = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_y_out", 32'(y_out), 32'h0);
    check("rst_y_valid", 32'(y_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Midscale DC, 20-cycle spacing
    for (int i = 0; i < 20; i++) begin
      run_sample(16'h0800, y, lat);
      check($sformatf("dc%0d_y", i), 32'(y), 32'h0);
      check($sformatf("dc%0d_lat", i), 32'(lat), 32'd18);
      repeat (2) @(negedge clk);
    end
    check("dc_overrun", 32'(overrun), 32'h0);

    // Back-to-back at minimum spacing through the whole table
    apply_rows(0, tbl.size() - 1, "vec");
    check("vec_overrun", 32'(overrun), 32'h0);

    // Overrun: second strobe five cycles after the first is dropped
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    d_out = 16'h0FFF;
    listo = 1'b1;
    @(negedge clk);
    nv   = 0;
    vlat = -1;
    yv   = '0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 5) check("ovr_before", 32'(overrun), 32'h0);
      if (c == 6) begin
        check("ovr_after", 32'(overrun), 32'h1);
        check("ovr_busy", 32'(busy), 32'h1);
      end
      if (y_valid) begin
        nv++;
        vlat = c;
        yv   = y_out;
      end
      listo = (c == 5);
      @(negedge clk);
    end
    check("ovr_nvalid", 32'(nv), 32'd1);
    check("ovr_lat", 32'(vlat), 32'd18);
    check("ovr_y", 32'(yv), 32'hFF00);
    // Delay line must hold only the one accepted impulse
    run_sample(16'h0800, y, lat);
    check("ovr_next_y", 32'(y), 32'h0000);
    run_sample(16'h0FFF, y, lat);
    check("ovr_next2_y", 32'(y), 32'h0100);
    check("ovr_sticky", 32'(overrun), 32'h1);

    // Reset eight cycles into a computation
    d_out = 16'h0800;
    listo = 1'b1;
    @(negedge clk);
    listo = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_y_out", 32'(y_out), 32'h0);
    check("mid_rst_y_valid", 32'(y_valid), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_overrun", 32'(overrun), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    nv = 0;
    for (int c = 0; c < 30; c++) begin
      if (y_valid) nv++;
      @(negedge clk);
    end
    check("mid_rst_nvalid", 32'(nv), 32'd0);
    apply_rows(0, 16, "post_rst");

`ifdef ADC_FIR_BYPASS_EN
    bypass = 1'b1;
    run_sample(16'h0000, y, lat);
    check("byp_min_y", 32'(y), 32'h8000);
    check("byp_min_lat", 32'(lat), 32'd18);
    run_sample(16'h0FFF, y, lat);
    check("byp_max_y", 32'(y), 32'h7FF0);
    bypass = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
